// File: rtl/bank_timing_guard.sv
// Per-bank DRAM timing guard: stalls bank commands until tRCD/tRAS/tRP/tCCD/tRTP/tWR/tRFC are met.
// Optional stall-cycle statistic enabled by defining BANK_TIMING_STALL_CNT_EN.
module bank_timing_guard #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned T_RCD     = 4,
  parameter int unsigned T_RAS     = 10,
  parameter int unsigned T_RP      = 4,
  parameter int unsigned T_CCD     = 2,
  parameter int unsigned T_RTP     = 3,
  parameter int unsigned T_WR      = 6,
  parameter int unsigned T_RFC     = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [2:0]           req_cmd,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 stall,
  output logic                 cmd_valid,
  output logic [2:0]           cmd_code,
  output logic [ADDR_BITS-1:0] cmd_addr,
  output logic                 proto_err,
  output logic [15:0]          stall_cnt
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned STAT_W = 16;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  localparam logic [CNT_W-1:0] L_RCD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] L_RAS = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] L_RP  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] L_CCD = CNT_W'(T_CCD - 1);
  localparam logic [CNT_W-1:0] L_RTP = CNT_W'(T_RTP - 1);
  localparam logic [CNT_W-1:0] L_WR  = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] L_RFC = CNT_W'(T_RFC - 1);

  logic [CNT_W-1:0]     r_rcd_cnt, r_ccd_cnt, r_pre_cnt, r_act_cnt;
  logic [CNT_W-1:0]     w_rcd_nxt, w_ccd_nxt, w_pre_nxt, w_act_nxt;
  logic [CNT_W-1:0]     w_pre_dec;
  logic                 r_cmd_valid;
  logic [2:0]           r_cmd_code;
  logic [ADDR_BITS-1:0] r_cmd_addr;
  logic                 r_proto_err;
  logic                 w_legal_code;
  logic                 w_ok;
  logic                 w_stall;
  logic                 w_issue;
  logic                 w_illegal;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  // Legality of the presented command against the current countdowns
  always_comb begin
    w_legal_code = 1'b1;
    w_ok         = 1'b1;
    case (req_cmd)
      CMD_NOP:          w_ok = 1'b1;
      CMD_ACT, CMD_REF: w_ok = (r_act_cnt == '0);
      CMD_RD, CMD_WR:   w_ok = (r_rcd_cnt == '0) && (r_ccd_cnt == '0);
      CMD_PRE:          w_ok = (r_pre_cnt == '0);
      default: begin
        w_legal_code = 1'b0;
        w_ok         = 1'b0;
      end
    endcase
    w_stall   = req_valid & w_legal_code & ~w_ok;
    w_issue   = req_valid & w_legal_code & w_ok & (req_cmd != CMD_NOP);
    w_illegal = req_valid & ~w_legal_code;
  end

  assign stall = w_stall;

  // Next counter values: loads on issue override saturating decrement
  always_comb begin
    w_pre_dec = sat_dec(r_pre_cnt);
    w_rcd_nxt = sat_dec(r_rcd_cnt);
    w_ccd_nxt = sat_dec(r_ccd_cnt);
    w_pre_nxt = w_pre_dec;
    w_act_nxt = sat_dec(r_act_cnt);
    if (w_issue) begin
      case (req_cmd)
        CMD_ACT: begin
          w_rcd_nxt = L_RCD;
          w_pre_nxt = L_RAS;
        end
        CMD_RD: begin
          w_ccd_nxt = L_CCD;
          w_pre_nxt = (w_pre_dec > L_RTP) ? w_pre_dec : L_RTP;
        end
        CMD_WR: begin
          w_ccd_nxt = L_CCD;
          w_pre_nxt = (w_pre_dec > L_WR) ? w_pre_dec : L_WR;
        end
        CMD_PRE: w_act_nxt = L_RP;
        CMD_REF: w_act_nxt = L_RFC;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcd_cnt   <= '0;
      r_ccd_cnt   <= '0;
      r_pre_cnt   <= '0;
      r_act_cnt   <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= '0;
      r_cmd_addr  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_rcd_cnt   <= w_rcd_nxt;
      r_ccd_cnt   <= w_ccd_nxt;
      r_pre_cnt   <= w_pre_nxt;
      r_act_cnt   <= w_act_nxt;
      r_cmd_valid <= w_issue;
      if (w_issue) begin
        r_cmd_code <= req_cmd;
        r_cmd_addr <= req_addr;
      end
      r_proto_err <= r_proto_err | w_illegal;
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_code  = r_cmd_code;
  assign cmd_addr  = r_cmd_addr;
  assign proto_err = r_proto_err;

`ifdef BANK_TIMING_STALL_CNT_EN
  logic [STAT_W-1:0] r_stall_cnt;

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {STAT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + STAT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = STAT_W'(0);
`endif

endmodule

// File: tb/tb_bank_timing_guard.sv
// Directed self-checking bench for bank_timing_guard with default timing parameters.
module tb_bank_timing_guard;

  localparam logic [2:0] NOP = 3'd0;
  localparam logic [2:0] ACT = 3'd1;
  localparam logic [2:0] RD  = 3'd2;
  localparam logic [2:0] WR  = 3'd3;
  localparam logic [2:0] PRE = 3'd4;
  localparam logic [2:0] REF = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_cmd;
  logic [15:0] req_addr;
  logic        stall;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [15:0] cmd_addr;
  logic        proto_err;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  bank_timing_guard dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_addr  (req_addr),
    .stall     (stall),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_addr  (cmd_addr),
    .proto_err (proto_err),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Present one request at a negedge, check stall, then check the registered result one edge later
  task automatic drive(input logic v, input logic [2:0] c, input logic [15:0] a,
                       input logic exp_stall, input logic exp_issue, input string tag);
    req_valid = v;
    req_cmd   = c;
    req_addr  = a;
    #1;
    chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    @(negedge clk);
    chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'(exp_issue));
    if (exp_issue) begin
      chk({tag, "_cmd_code"}, 32'(cmd_code), 32'(c));
      chk({tag, "_cmd_addr"}, 32'(cmd_addr), 32'(a));
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    req_cmd   = NOP;
    req_addr  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_code",  32'(cmd_code),  32'd0);
    chk("rst_cmd_addr",  32'(cmd_addr),  32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // ACT -> RD (tRCD), RD -> RD (tCCD), then PRE held off by tRAS
    drive(1'b1, ACT, 16'h1234, 1'b0, 1'b1, "t1_act");
    for (int i = 1; i <= 3; i++) drive(1'b1, RD, 16'h0040, 1'b1, 1'b0, "t1_rd_wait");
    drive(1'b1, RD, 16'h0040, 1'b0, 1'b1, "t1_rd");
    drive(1'b1, RD, 16'h0041, 1'b1, 1'b0, "t1_rd2_wait");
    drive(1'b1, RD, 16'h0041, 1'b0, 1'b1, "t1_rd2");
    for (int i = 7; i <= 9; i++) drive(1'b1, PRE, 16'h0000, 1'b1, 1'b0, "t1_pre_wait");
    drive(1'b1, PRE, 16'h0000, 1'b0, 1'b1, "t1_pre");
    drive(1'b1, NOP, 16'h0000, 1'b0, 1'b0, "t1_nop");
    drive(1'b0, NOP, 16'h0000, 1'b0, 1'b0, "t1_idle");

    // WR -> PRE governed by write recovery
    do_reset();
    drive(1'b1, ACT, 16'h0010, 1'b0, 1'b1, "t2_act");
    for (int i = 1; i <= 3; i++) drive(1'b0, NOP, 16'h0000, 1'b0, 1'b0, "t2_gap");
    drive(1'b1, WR, 16'h0022, 1'b0, 1'b1, "t2_wr");
    for (int i = 5; i <= 9; i++) drive(1'b1, PRE, 16'h0000, 1'b1, 1'b0, "t2_pre_wait");
    drive(1'b1, PRE, 16'h0000, 1'b0, 1'b1, "t2_pre");

    // PRE -> REF (tRP) -> ACT (tRFC)
    do_reset();
    drive(1'b1, PRE, 16'h0000, 1'b0, 1'b1, "t3_pre");
    for (int i = 1; i <= 3; i++) drive(1'b1, REF, 16'h0000, 1'b1, 1'b0, "t3_ref_wait");
    drive(1'b1, REF, 16'h0000, 1'b0, 1'b1, "t3_ref");
    for (int i = 5; i <= 23; i++) drive(1'b1, ACT, 16'h0777, 1'b1, 1'b0, "t3_act_wait");
    drive(1'b1, ACT, 16'h0777, 1'b0, 1'b1, "t3_act");

    // Illegal codes set a sticky error without stalling or issuing
    drive(1'b1, 3'd6, 16'h0000, 1'b0, 1'b0, "t4_ill6");
    chk("t4_proto_err_set", 32'(proto_err), 32'd1);
    drive(1'b1, 3'd7, 16'h0000, 1'b0, 1'b0, "t4_ill7");
    drive(1'b0, NOP, 16'h0000, 1'b0, 1'b0, "t4_idle");
    chk("t4_proto_err_held", 32'(proto_err), 32'd1);
    drive(1'b1, REF, 16'h0000, 1'b0, 1'b1, "t4_ref");
    drive(1'b1, ACT, 16'h0abc, 1'b1, 1'b0, "t4_act_blocked");

    // Reset with tRFC pending discards it
    do_reset();
    chk("t5_proto_err", 32'(proto_err), 32'd0);
    chk("t5_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("t5_cmd_code",  32'(cmd_code),  32'd0);
    drive(1'b1, ACT, 16'h0abc, 1'b0, 1'b1, "t5_act");

    // Stall statistic: REF held for 1053 cycles gives 1000 stalled cycles
    do_reset();
    for (int i = 0; i < 1053; i++)
      drive(1'b1, REF, 16'h0000, (i % 20) != 0, (i % 20) == 0, "t6_ref");
`ifdef BANK_TIMING_STALL_CNT_EN
    chk("t6_stall_cnt", 32'(stall_cnt), 32'd1000);
`else
    chk("t6_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    drive(1'b0, NOP, 16'h0000, 1'b0, 1'b0, "t6_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
